// File: rtl/synth_pkg.sv
// Shared definitions for the tone-generator key scheduler: note count,
// arbiter states, note half-period table and small selection helpers.
// The ARP state is present only when KEY_SCHED_ARP_EN is defined.
package synth_pkg;

    localparam int NUM_NOTES = 7;

`ifdef KEY_SCHED_ARP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ARP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
    } state_t;
`endif

    // Speaker half-periods in 100 MHz clk cycles, notes C..B.
    localparam logic [31:0] NOTE_HALF_PERIOD [NUM_NOTES] = '{
        32'd191113, 32'd170262, 32'd151685, 32'd143172,
        32'd127551, 32'd113636, 32'd101240
    };

    // Lowest set bit index; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [NUM_NOTES-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [2:0] next_held(input logic [NUM_NOTES-1:0] v,
                                             input logic [2:0]           cur);
        logic [2:0] r;
        logic       found;
        r     = lowest_set(v);
        found = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (!found && (i > int'(cur)) && v[i]) begin
                r     = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low button.
// o_level flips on the DEBOUNCE_CYCLES-th consecutive synchronized sample
// that disagrees with it; any agreeing sample restarts the count.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize the raw button and accept a new level only after a full stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/key_scheduler.sv
// Key scheduler: debounces eight active-low buttons and arbitrates the seven
// note keys with last-note priority, driving a registered half-period divisor,
// tone enable and a note_valid pulse to the square-wave datapath.
// Optional arpeggiator on btn[7] is enabled by defining KEY_SCHED_ARP_EN.
module key_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ARP_CYCLES      = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  btn,
    output logic [31:0] half_period,
    output logic        tone_en,
    output logic [2:0]  note_idx,
    output logic        note_valid
);

    import synth_pkg::*;

    logic [7:0]           w_level;
    logic [NUM_NOTES-1:0] w_held;
    logic [NUM_NOTES-1:0] w_press;
    logic [NUM_NOTES-1:0] w_release;
    logic [2:0]           w_press_idx;
    logic [2:0]           w_low_held;
    logic [NUM_NOTES-1:0] r_held_prev;
    state_t               r_state;

    for (genvar g = 0; g < 8; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (btn[g]),
            .o_level (w_level[g])
        );
    end

    // Press/release events are edges of the debounced (active-low) levels.
    assign w_held      = ~w_level[NUM_NOTES-1:0];
    assign w_press     = w_held & ~r_held_prev;
    assign w_release   = ~w_held & r_held_prev;
    assign w_press_idx = lowest_set(w_press);
    assign w_low_held  = lowest_set(w_held);

`ifdef KEY_SCHED_ARP_EN
    localparam int               ARP_W    = $clog2(ARP_CYCLES);
    localparam logic [ARP_W-1:0] ARP_LAST = ARP_W'(ARP_CYCLES - 1);

    logic             w_arp_held;
    logic [2:0]       w_arp_next;
    logic [ARP_W-1:0] r_arp_cnt;

    assign w_arp_held = ~w_level[7];
    assign w_arp_next = next_held(w_held, note_idx);
`else
    localparam int unused_arp_cycles = ARP_CYCLES;
    logic w_unused_arp_key;
    assign w_unused_arp_key = w_level[7];
`endif

    // Arbiter FSM: outputs are registered so each decision lands on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_held_prev <= '0;
            tone_en     <= 1'b0;
            note_idx    <= 3'd0;
            half_period <= 32'd0;
            note_valid  <= 1'b0;
`ifdef KEY_SCHED_ARP_EN
            r_arp_cnt   <= '0;
`endif
        end else begin
            r_held_prev <= w_held;
            note_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_press) begin
                        r_state     <= ST_HOLD;
                        tone_en     <= 1'b1;
                        note_idx    <= w_press_idx;
                        half_period <= NOTE_HALF_PERIOD[w_press_idx];
                        note_valid  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (|w_press) begin
                        // Newest press wins; the held current note cannot be a new press.
                        if (w_press_idx != note_idx) begin
                            note_idx    <= w_press_idx;
                            half_period <= NOTE_HALF_PERIOD[w_press_idx];
                            note_valid  <= 1'b1;
                        end
                    end else if (w_release[note_idx]) begin
                        if (|w_held) begin
                            note_idx    <= w_low_held;
                            half_period <= NOTE_HALF_PERIOD[w_low_held];
                            note_valid  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            tone_en <= 1'b0;
                        end
                    end
`ifdef KEY_SCHED_ARP_EN
                    if (w_arp_held && (|w_held)) begin
                        r_state   <= ST_ARP;
                        r_arp_cnt <= '0;
                    end
`endif
                end
`ifdef KEY_SCHED_ARP_EN
                ST_ARP: begin
                    if (!(|w_held)) begin
                        r_state <= ST_IDLE;
                        tone_en <= 1'b0;
                    end else if (!w_arp_held) begin
                        // Keep the current note unless it was let go during the arpeggio.
                        r_state <= ST_HOLD;
                        if (!w_held[note_idx]) begin
                            note_idx    <= w_low_held;
                            half_period <= NOTE_HALF_PERIOD[w_low_held];
                            note_valid  <= 1'b1;
                        end
                    end else if (r_arp_cnt == ARP_LAST) begin
                        r_arp_cnt   <= '0;
                        note_idx    <= w_arp_next;
                        half_period <= NOTE_HALF_PERIOD[w_arp_next];
                        note_valid  <= 1'b1;
                    end else begin
                        r_arp_cnt <= r_arp_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    tone_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_scheduler.sv
// Self-checking bench for key_scheduler with DEBOUNCE_CYCLES=4, ARP_CYCLES=8.
// Directed steps follow the block's behaviour; a randomized phase compares the
// DUT against a set-based model of the note arbitration rules.
// Arpeggio steps are exercised when KEY_SCHED_ARP_EN is defined.
module tb_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  btn;
    logic [31:0] half_period;
    logic        tone_en;
    logic [2:0]  note_idx;
    logic        note_valid;

    int checks = 0;
    int errors = 0;
    int nv_cnt = 0;

    // Reference model state
    logic [6:0]  m_held   = 7'd0;
    logic        m_active = 1'b0;
    logic [2:0]  m_cur    = 3'd0;
    logic [31:0] m_hp     = 32'd0;

    key_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .ARP_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .half_period (half_period),
        .tone_en     (tone_en),
        .note_idx    (note_idx),
        .note_valid  (note_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] hp_of(input int i);
        case (i)
            0: return 32'd191113;
            1: return 32'd170262;
            2: return 32'd151685;
            3: return 32'd143172;
            4: return 32'd127551;
            5: return 32'd113636;
            6: return 32'd101240;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] lowest(input logic [6:0] v);
        for (int i = 0; i < 7; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (note_valid === 1'b1) nv_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_tone_en"}, 64'(tone_en), 64'(m_active));
        check({tag, "_note_idx"}, 64'(note_idx), 64'(m_cur));
        check({tag, "_half_period"}, 64'(half_period), 64'(m_hp));
    endtask

    // Arbitration rules applied to one simultaneous change of the held set.
    task automatic model_update(input logic [6:0] nh, output int pulses);
        logic [6:0] pr;
        logic [6:0] rl;
        logic [2:0] n;
        pr     = nh & ~m_held;
        rl     = ~nh & m_held;
        pulses = 0;
        if (pr != 7'd0) begin
            n = lowest(pr);
            if (!m_active || n != m_cur) pulses = 1;
            m_cur    = n;
            m_active = 1'b1;
            m_hp     = hp_of(int'(n));
        end else if (m_active && rl[m_cur]) begin
            if (nh != 7'd0) begin
                m_cur  = lowest(nh);
                m_hp   = hp_of(int'(m_cur));
                pulses = 1;
            end else begin
                m_active = 1'b0;
            end
        end
        m_held = nh;
    endtask

    task automatic model_reset();
        m_held   = 7'd0;
        m_active = 1'b0;
        m_cur    = 3'd0;
        m_hp     = 32'd0;
    endtask

    // Drive a new held set (optionally preceded by a short bounce) and check the outcome.
    task automatic apply(input logic [6:0] nh, input string tag, input bit bounce, input int bk);
        int exp_p;
        nv_cnt = 0;
        if (bounce) begin
            btn[bk] = ~btn[bk];
            steps(3);
            btn[bk] = ~btn[bk];
            step();
        end
        btn[6:0] = ~nh;
        steps(10);
        model_update(nh, exp_p);
        check_state(tag);
        check({tag, "_pulses"}, 64'(nv_cnt), 64'(exp_p));
    endtask

    initial begin
        int p;
        logic [6:0] nh;
        rst_n = 1'b0;
        btn   = 8'hFF;
        steps(3);
        check("in_reset", {tone_en, note_idx, half_period, note_valid}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("reset_idle", {tone_en, note_idx, half_period, note_valid}, 64'd0);
        end

        // Single press of key 2: exact latency of 7 cycles
        nv_cnt = 0;
        btn[2] = 1'b0;
        steps(6);
        check("lat_before", 64'(tone_en), 64'd0);
        step();
        check("lat_tone_en", 64'(tone_en), 64'd1);
        check("lat_note_idx", 64'(note_idx), 64'd2);
        check("lat_half_period", 64'(half_period), 64'd151685);
        check("lat_valid", 64'(note_valid), 64'd1);
        steps(5);
        check("lat_pulses", 64'(nv_cnt), 64'd1);
        model_update(7'b0000100, p);

        // Bounce on key 4 shorter than the debounce window
        nv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn[4] = 1'b0;
            steps(3);
            btn[4] = 1'b1;
            step();
            check("bounce_idx", 64'(note_idx), 64'd2);
        end
        steps(8);
        check_state("bounce");
        check("bounce_pulses", 64'(nv_cnt), 64'd0);
        apply(7'b0000000, "rel2", 1'b0, 0);

        // Last-note priority and fallback to held note
        apply(7'b0100000, "hold5", 1'b0, 0);
        apply(7'b0100010, "press1", 1'b0, 0);
        check("press1_hp", 64'(half_period), 64'd170262);
        apply(7'b0100000, "rel1", 1'b0, 0);
        check("rel1_idx", 64'(note_idx), 64'd5);
        apply(7'b0000000, "rel5", 1'b0, 0);
        check("rel5_hp", 64'(half_period), 64'd113636);

        // Simultaneous press, then asynchronous reset mid-note
        apply(7'b1001000, "press36", 1'b0, 0);
        check("press36_idx", 64'(note_idx), 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset", {tone_en, note_idx, half_period, note_valid}, 64'd0);
        steps(2);
        rst_n = 1'b1;
        model_reset();
        nv_cnt = 0;
        steps(6);
        check("rearm_before", 64'(tone_en), 64'd0);
        step();
        check("rearm_idx", 64'(note_idx), 64'd3);
        check("rearm_hp", 64'(half_period), 64'd143172);
        model_update(7'b1001000, p);
        check_state("rearm");
        steps(3);
        check("rearm_pulses", 64'(nv_cnt), 64'(p));
        apply(7'b0000000, "rel36", 1'b0, 0);

        apply(7'b0010101, "chord024", 1'b0, 0);
`ifdef KEY_SCHED_ARP_EN
        // Arpeggio across keys 0, 2, 4
        nv_cnt = 0;
        btn[7] = 1'b0;
        steps(14);
        check("arp_hold0", 64'(note_idx), 64'd0);
        step();
        check("arp_step2", 64'(note_idx), 64'd2);
        check("arp_step2_v", 64'(note_valid), 64'd1);
        steps(7);
        check("arp_hold2", 64'(note_idx), 64'd2);
        step();
        check("arp_step4", 64'(note_idx), 64'd4);
        check("arp_step4_v", 64'(note_valid), 64'd1);
        steps(8);
        check("arp_wrap0", 64'(note_idx), 64'd0);
        check("arp_wrap0_hp", 64'(half_period), 64'd191113);
        check("arp_pulses", 64'(nv_cnt), 64'd3);
        nv_cnt = 0;
        btn[7] = 1'b1;
        steps(30);
        check("arp_stop_idx", 64'(note_idx), 64'd0);
        check("arp_stop_pulses", 64'(nv_cnt), 64'd0);
        check_state("arp_stop");
`else
        // btn[7] has no effect without the arpeggiator
        nv_cnt = 0;
        btn[7] = 1'b0;
        steps(30);
        check_state("btn7_ignored");
        check("btn7_pulses", 64'(nv_cnt), 64'd0);
        btn[7] = 1'b1;
        steps(10);
`endif
        apply(7'b0000000, "rel024", 1'b0, 0);

        // Randomized held-set changes with occasional sub-window bounces
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       nh = 7'($urandom_range(0, 127));
                1:       nh = m_held ^ (7'd1 << $urandom_range(0, 6));
                default: nh = m_held ^ (7'd1 << $urandom_range(0, 6)) ^ (7'd1 << $urandom_range(0, 6));
            endcase
`ifndef KEY_SCHED_ARP_EN
            btn[7] = 1'($urandom_range(0, 1));
`endif
            apply(nh, "rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end
        apply(7'b0000000, "final", 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
